// File: rtl/barrett_param_gen.sv
// barrett_param_gen
// Derives the Barrett reduction constants for a modulus m:
//   k            = bit length of m
//   md           = floor(2^(2k) / m), computed by bit-serial restoring division
//   k_shft_ah    = (k>>1)-1
//   k_shft_ahxmd = (k>>1)+1
// Results are registered and held until the next accepted request, so they can
// feed the Barrett multiplier's constant inputs directly.

module barrett_param_gen #(
    parameter int NBITS = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_p,
    input  logic [NBITS-1:0]           m,
    output logic [NBITS-1:0]           m_q,
    output logic [NBITS:0]             md,
    output logic [$clog2(NBITS)+1:0]   k,
    output logic [$clog2(NBITS):0]     k_shft_ah,
    output logic [$clog2(NBITS):0]     k_shft_ahxmd,
    output logic                       busy,
    output logic                       done_p,
    output logic                       err,
    output logic                       params_vld
);

    localparam int KW = $clog2(NBITS) + 2;
    localparam int SW = $clog2(NBITS) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        DIV,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [NBITS:0]     r;          // running remainder, always < m_q
    logic [NBITS:0]     q;          // quotient bits shifted in MSB first
    logic [KW-1:0]      cnt;        // remaining division iterations
    logic               bad;        // modulus rejected in LEAD

    logic [KW-1:0]      lead_k;
    logic [KW-1:0]      lead_half;
    logic               lead_bad;
    logic [NBITS+1:0]   t;
    logic               t_ge;
    logic [NBITS:0]     r_sub;
    logic               div_last;

    // Bit length of v: index of the most significant set bit plus one, 0 for v=0.
    function automatic logic [KW-1:0] bit_len(input logic [NBITS-1:0] v);
        logic [KW-1:0] len;
        len = '0;
        for (int i = 0; i < NBITS; i++) begin
            if (v[i]) begin
                len = KW'(i + 1);
            end
        end
        return len;
    endfunction

    assign lead_k    = bit_len(m_q);
    assign lead_half = lead_k >> 1;
    // Zero and powers of two (including 1) both satisfy m & (m-1) == 0.
    assign lead_bad  = ((m_q & (m_q - 1'b1)) == '0);

    // One restoring-division step: double the remainder (one extra bit so it
    // cannot overflow) and subtract the modulus when it fits. The difference
    // is below m_q, so NBITS+1 bits of it are exact.
    assign t         = {r, 1'b0};
    assign t_ge      = (t >= {2'b00, m_q});
    assign r_sub     = t[NBITS:0] - {1'b0, m_q};
    assign div_last  = (cnt == KW'(1));

    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; requests are only honoured from IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_p) state_nxt = LEAD;
            LEAD: state_nxt = lead_bad ? DONE : DIV;
            DIV:  if (div_last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and result registers, advanced according to the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q          <= '0;
            md           <= '0;
            k            <= '0;
            k_shft_ah    <= '0;
            k_shft_ahxmd <= '0;
            done_p       <= 1'b0;
            err          <= 1'b0;
            params_vld   <= 1'b0;
            r            <= '0;
            q            <= '0;
            cnt          <= '0;
            bad          <= 1'b0;
        end else begin
            done_p <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_p) begin
                        m_q        <= m;
                        params_vld <= 1'b0;
                        err        <= 1'b0;
                    end
                end
                LEAD: begin
                    q <= '0;
                    if (lead_bad) begin
                        bad          <= 1'b1;
                        k            <= '0;
                        k_shft_ah    <= '0;
                        k_shft_ahxmd <= '0;
                        r            <= '0;
                        cnt          <= '0;
                    end else begin
                        // The first k dividend bits of 2^(2k) leave remainder
                        // 2^(k-1) with quotient 0, since m > 2^(k-1); the
                        // remaining k+1 zero bits are divided serially.
                        bad          <= 1'b0;
                        k            <= lead_k;
                        k_shft_ah    <= SW'(lead_half - KW'(1));
                        k_shft_ahxmd <= SW'(lead_half + KW'(1));
                        r            <= {{NBITS{1'b0}}, 1'b1} << (lead_k - KW'(1));
                        cnt          <= lead_k + KW'(1);
                    end
                end
                DIV: begin
                    r   <= t_ge ? r_sub : t[NBITS:0];
                    q   <= {q[NBITS-1:0], t_ge};
                    cnt <= cnt - KW'(1);
                end
                DONE: begin
                    md         <= q;
                    done_p     <= 1'b1;
                    err        <= bad;
                    params_vld <= ~bad;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_barrett_param_gen.sv
// Scoreboard bench for barrett_param_gen: stimulus queues expected results,
// a negedge monitor compares them whenever done_p is presented.

module tb_barrett_param_gen;

    localparam int NBITS = 128;
    localparam int KW    = $clog2(NBITS) + 2;
    localparam int SW    = $clog2(NBITS) + 1;

    localparam logic [NBITS-1:0] ALL1   = '1;
    localparam logic [NBITS:0]   MD_BIG = {1'b1, {(NBITS-1){1'b0}}, 1'b1};

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start_p;
    logic [NBITS-1:0]   m;
    logic [NBITS-1:0]   m_q;
    logic [NBITS:0]     md;
    logic [KW-1:0]      k;
    logic [SW-1:0]      k_shft_ah;
    logic [SW-1:0]      k_shft_ahxmd;
    logic               busy;
    logic               done_p;
    logic               err;
    logic               params_vld;

    always #5 clk = ~clk;

    barrett_param_gen #(.NBITS(NBITS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_p      (start_p),
        .m            (m),
        .m_q          (m_q),
        .md           (md),
        .k            (k),
        .k_shft_ah    (k_shft_ah),
        .k_shft_ahxmd (k_shft_ahxmd),
        .busy         (busy),
        .done_p       (done_p),
        .err          (err),
        .params_vld   (params_vld)
    );

    typedef struct {
        logic [NBITS-1:0] mq;
        logic [NBITS:0]   md;
        logic [KW-1:0]    k;
        logic [SW-1:0]    ah;
        logic [SW-1:0]    ax;
        logic             err;
        int               start;
        int               lat;
    } exp_t;

    exp_t sbq[$];

    int cyc     = 0;
    int checks  = 0;
    int errors  = 0;
    int rst_req = 0;
    int rst_ack = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [NBITS:0] act, input logic [NBITS:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: reset-state checks on request, result checks on done_p,
    // and a latency bound on every outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_req != rst_ack) begin
            cmp("rst_m_q",        {1'b0, m_q},                  '0);
            cmp("rst_md",         md,                           '0);
            cmp("rst_k",          (NBITS+1)'(k),                '0);
            cmp("rst_k_shft_ah",  (NBITS+1)'(k_shft_ah),        '0);
            cmp("rst_k_shft_ahxmd", (NBITS+1)'(k_shft_ahxmd),   '0);
            cmp("rst_busy",       (NBITS+1)'(busy),             '0);
            cmp("rst_done_p",     (NBITS+1)'(done_p),           '0);
            cmp("rst_err",        (NBITS+1)'(err),              '0);
            cmp("rst_params_vld", (NBITS+1)'(params_vld),       '0);
            rst_ack = rst_ack + 1;
        end else if (rst_n && done_p) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_p=1 expected done_p=0 at cycle %0d", cyc);
            end else begin
                e = sbq.pop_front();
                cmp("latency",      (NBITS+1)'(cyc - e.start),   (NBITS+1)'(e.lat));
                cmp("m_q",          {1'b0, m_q},                 {1'b0, e.mq});
                cmp("md",           md,                          e.md);
                cmp("k",            (NBITS+1)'(k),               (NBITS+1)'(e.k));
                cmp("k_shft_ah",    (NBITS+1)'(k_shft_ah),       (NBITS+1)'(e.ah));
                cmp("k_shft_ahxmd", (NBITS+1)'(k_shft_ahxmd),    (NBITS+1)'(e.ax));
                cmp("err",          (NBITS+1)'(err),             (NBITS+1)'(e.err));
                cmp("params_vld",   (NBITS+1)'(params_vld),      (NBITS+1)'(!e.err));
            end
        end else if (sbq.size() > 0 && cyc > sbq[0].start + sbq[0].lat + 4) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no done_p by cycle %0d expected at cycle %0d",
                     cyc, sbq[0].start + sbq[0].lat);
            void'(sbq.pop_front());
        end
    end

    // Drive a one-cycle request (called on a negedge); optionally queue its result.
    task automatic issue(input logic [NBITS-1:0] mv, input logic [NBITS:0] mdv,
                         input int kv, input int ahv, input int axv, input logic errv,
                         input logic [NBITS-1:0] mqv, input bit push);
        exp_t e;
        start_p = 1'b1;
        m       = mv;
        if (push) begin
            e.mq    = mqv;
            e.md    = mdv;
            e.k     = KW'(kv);
            e.ah    = SW'(ahv);
            e.ax    = SW'(axv);
            e.err   = errv;
            e.start = cyc + 1;
            e.lat   = errv ? 2 : kv + 3;
            sbq.push_back(e);
        end
        @(negedge clk);
        start_p = 1'b0;
        m       = '0;
    endtask

    task automatic wait_done(input int maxc);
        for (int i = 0; i < maxc && sbq.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    // Hold reset across one rising edge and have the monitor check outputs.
    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        rst_req++;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        start_p = 1'b0;
        m       = '0;
        repeat (2) @(negedge clk);
        pulse_reset();
        @(negedge clk);

        issue(3,  5,  2, 0, 2, 1'b0, 3,  1'b1);  wait_done(50);
        issue(13, 19, 4, 1, 3, 1'b0, 13, 1'b1);  wait_done(50);
        issue(ALL1, MD_BIG, 128, 63, 65, 1'b0, ALL1, 1'b1);  wait_done(200);
        issue(8, 0, 0, 0, 0, 1'b1, 8, 1'b1);     wait_done(20);
        issue(0, 0, 0, 0, 0, 1'b1, 0, 1'b1);     wait_done(20);

        // Second request two cycles into a running job must be ignored.
        issue(13, 19, 4, 1, 3, 1'b0, 13, 1'b1);
        @(negedge clk);
        issue(3, 5, 2, 0, 2, 1'b0, 3, 1'b0);
        wait_done(50);

        // Abort a long job mid-division; it must never report completion.
        issue(ALL1, MD_BIG, 128, 63, 65, 1'b0, ALL1, 1'b0);
        repeat (50) @(negedge clk);
        pulse_reset();
        repeat (150) @(negedge clk);
        issue(3, 5, 2, 0, 2, 1'b0, 3, 1'b1);     wait_done(50);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
